// File: rtl/ipsxe_floating_point_a3_y_mult_seq_v1_0.sv
// Sequential shift-add multiplier forming a3*y for the invsqrt datapath.
// Emits P[2*HALF_W-10 -: OUT_W] and flags any set bit in the top 9 product bits.
module ipsxe_floating_point_a3_y_mult_seq_v1_0 #(
  parameter int unsigned MAN_WIDTH = 52,
  parameter int unsigned RNE       = 2,
  parameter int unsigned RNE1      = 49,
  parameter int unsigned RNE2      = 44,
  parameter int unsigned DIGIT_W   = 4,
  localparam int unsigned HALF_W   = ((MAN_WIDTH + 1) + RNE + RNE1) / 2,
  localparam int unsigned OUT_W    = HALF_W + RNE2 - 9
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [HALF_W-1:0] i_a3,
  input  logic [HALF_W-1:0] i_y,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [OUT_W-1:0]  o_a3_y_rne2_dlt9zeros,
  output logic              o_hi_nz
);

  localparam int unsigned N      = (HALF_W + DIGIT_W - 1) / DIGIT_W;
  localparam int unsigned YPAD_W = N * DIGIT_W;
  localparam int unsigned ACC_W  = 2 * HALF_W;
  localparam int unsigned CNT_W  = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned HI_LSB = ACC_W - 9;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   a3_sh_q, a3_sh_d;
  logic [YPAD_W-1:0]  y_sh_q, y_sh_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [OUT_W-1:0]   result_q, result_d;
  logic               hi_nz_q, hi_nz_d;
  logic               valid_q, valid_d;

  logic [DIGIT_W-1:0] digit_c;
  logic [ACC_W-1:0]   acc_sum_c;
  logic               last_c;
  logic               accept_c;

  assign o_ready   = (state_q == S_IDLE) && i_rst_n;
  assign accept_c  = i_valid && o_ready;
  assign last_c    = (cnt_q == CNT_W'(N - 1));
  // a3 is pre-shifted to the current digit weight, y is consumed LSB digit first
  assign digit_c   = y_sh_q[DIGIT_W-1:0];
  assign acc_sum_c = acc_q + a3_sh_q * ACC_W'(digit_c);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept_c) state_d = S_RUN;
      S_RUN:   if (last_c)   state_d = S_DONE;
      S_DONE:  if (i_ready)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    a3_sh_d  = a3_sh_q;
    y_sh_d   = y_sh_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    hi_nz_d  = hi_nz_q;
    valid_d  = valid_q;
    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          a3_sh_d = ACC_W'(i_a3);
          y_sh_d  = YPAD_W'(i_y);
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        acc_d   = acc_sum_c;
        a3_sh_d = a3_sh_q << DIGIT_W;
        y_sh_d  = y_sh_q >> DIGIT_W;
        if (last_c) begin
          result_d = acc_sum_c[HI_LSB-1 -: OUT_W];
          hi_nz_d  = |acc_sum_c[ACC_W-1:HI_LSB];
          valid_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        if (i_ready) valid_d = 1'b0;
      end
      default: valid_d = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      a3_sh_q  <= '0;
      y_sh_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      hi_nz_q  <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      a3_sh_q  <= a3_sh_d;
      y_sh_q   <= y_sh_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      hi_nz_q  <= hi_nz_d;
      valid_q  <= valid_d;
    end
  end

  assign o_valid               = valid_q;
  assign o_a3_y_rne2_dlt9zeros = result_q;
  assign o_hi_nz               = hi_nz_q;

endmodule
